// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests the word at pc, holds it for decode, steers the PC.
// Optional FETCH_TIMEOUT_EN adds a bounded memory wait with a sticky error and HALT state.
module fetch_unit #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              flush_i,
    output logic              pc_enable_o,
    output logic              pc_select_o,
    output logic              fetch_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ADVANCE,
        S_HOLD,
`ifdef FETCH_TIMEOUT_EN
        S_REDIRECT,
        S_HALT
`else
        S_REDIRECT
`endif
    } state_e;

    state_e            state_q;
    logic              memReq_q;
    logic              pcEnable_q;
    logic              pcSelect_q;
    logic              instrValid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instrPc_q;
    logic              fetchErr_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] waitCnt_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Outputs are registered alongside the state, so each is set for the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            memReq_q     <= 1'b0;
            pcEnable_q   <= 1'b0;
            pcSelect_q   <= 1'b0;
            instrValid_q <= 1'b0;
            instr_q      <= '0;
            instrPc_q    <= '0;
            fetchErr_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            waitCnt_q    <= '0;
`endif
        end else begin
            memReq_q   <= 1'b0;
            pcEnable_q <= 1'b0;
            pcSelect_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_FETCH;
                    memReq_q <= 1'b1;
                end
                S_FETCH: begin
                    if (flush_i) begin
                        state_q      <= S_REDIRECT;
                        instrValid_q <= 1'b0;
                        pcEnable_q   <= 1'b1;
                        pcSelect_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        waitCnt_q    <= '0;
`endif
                    end else if (mem_ready_i) begin
                        state_q      <= S_ADVANCE;
                        instr_q      <= mem_rdata_i;
                        instrPc_q    <= pc_i;
                        instrValid_q <= 1'b1;
                        pcEnable_q   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        waitCnt_q    <= '0;
`endif
                    end else begin
`ifdef FETCH_TIMEOUT_EN
                        // This wait cycle is the one that brings the count up to the limit.
                        if (waitCnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                            state_q      <= S_HALT;
                            fetchErr_q   <= 1'b1;
                            instrValid_q <= 1'b0;
                            waitCnt_q    <= '0;
                        end else begin
                            waitCnt_q <= waitCnt_q + CntW'(1);
                            memReq_q  <= 1'b1;
                        end
`else
                        memReq_q <= 1'b1;
`endif
                    end
                end
                S_ADVANCE, S_HOLD: begin
                    if (flush_i) begin
                        state_q      <= S_REDIRECT;
                        instrValid_q <= 1'b0;
                        pcEnable_q   <= 1'b1;
                        pcSelect_q   <= 1'b1;
                    end else if (instr_ready_i) begin
                        state_q      <= S_FETCH;
                        instrValid_q <= 1'b0;
                        memReq_q     <= 1'b1;
                    end else begin
                        state_q <= S_HOLD;
                    end
                end
                S_REDIRECT: begin
                    if (flush_i) begin
                        state_q    <= S_REDIRECT;
                        pcEnable_q <= 1'b1;
                        pcSelect_q <= 1'b1;
                    end else begin
                        state_q  <= S_FETCH;
                        memReq_q <= 1'b1;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                S_HALT: state_q <= S_HALT;
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_req_o     = memReq_q;
    assign mem_addr_o    = memReq_q ? pc_i : '0;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instrPc_q;
    assign instr_valid_o = instrValid_q;
    assign pc_enable_o   = pcEnable_q;
    assign pc_select_o   = pcSelect_q;
    assign fetch_err_o   = fetchErr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps then a random phase, checked against
// a transaction-level model (program counter, memory image, expected instruction stream).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic [15:0] pcModel = 16'h0000;
    logic        memReq;
    logic [15:0] memAddr;
    logic [15:0] memRdata;
    logic        memReady = 1'b0;
    logic [15:0] instr;
    logic [15:0] instrPc;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic        flush = 1'b0;
    logic        pcEnable;
    logic        pcSelect;
    logic        fetchErr;

    logic [15:0] memImg [256];
    logic [15:0] busVal = 16'h0000;

    logic        expValid = 1'b0;
    logic [15:0] expInstr = 16'h0000;
    logic [15:0] expInstrPc = 16'h0000;
    logic [15:0] expNextAddr = 16'h0000;
    logic        expErr = 1'b0;

    int checks = 0;
    int passes = 0;
    int completions = 0;
    int pcEnCount = 0;
    int waitRun = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .pc_i          (pcModel),
        .mem_req_o     (memReq),
        .mem_addr_o    (memAddr),
        .mem_rdata_i   (memRdata),
        .mem_ready_i   (memReady),
        .instr_o       (instr),
        .instr_pc_o    (instrPc),
        .instr_valid_o (instrValid),
        .instr_ready_i (instrReady),
        .flush_i       (flush),
        .pc_enable_o   (pcEnable),
        .pc_select_o   (pcSelect),
        .fetch_err_o   (fetchErr)
    );

    assign memRdata = memImg[pcModel[7:0]];

    // Behavioural program_counter: +1 or bus load whenever the fetch unit enables it.
    always @(posedge clk) begin
        if (pcEnable) begin
            pcModel   <= pcSelect ? busVal : pcModel + 16'd1;
            pcEnCount <= pcEnCount + 1;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One cycle: drive inputs, compare outputs with the model, advance the model, clock.
    task automatic stepCycle(input logic rdy, input logic irdy, input logic fl, input logic [15:0] bus);
        memReady   = rdy;
        instrReady = irdy;
        flush      = fl;
        if (fl) busVal = bus;
        checkVal("instr_valid", 32'(instrValid), 32'(expValid));
        checkVal("instr", 32'(instr), 32'(expInstr));
        checkVal("instr_pc", 32'(instrPc), 32'(expInstrPc));
        checkVal("mem_addr", 32'(memAddr), memReq ? 32'(pcModel) : 32'd0);
        checkVal("req_vs_pcen", 32'(memReq & pcEnable), 32'd0);
        checkVal("fetch_err", 32'(fetchErr), 32'(expErr));
        if (memReq && !rdy) waitRun++;
        else waitRun = 0;
        if (fl) begin
            expValid    = 1'b0;
            expNextAddr = bus;
        end else if (memReq && rdy) begin
            checkVal("fetch_addr", 32'(pcModel), 32'(expNextAddr));
            expValid    = 1'b1;
            expInstr    = memImg[pcModel[7:0]];
            expInstrPc  = pcModel;
            expNextAddr = pcModel + 16'd1;
            completions++;
        end else if (expValid && irdy) begin
            expValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        expValid    = 1'b0;
        expInstr    = 16'h0000;
        expInstrPc  = 16'h0000;
        expErr      = 1'b0;
        expNextAddr = pcModel;
        waitRun     = 0;
    endtask

    initial begin
        int pcEnStart;
        int randStart;
        logic rdy, irdy, fl;

        for (int i = 0; i < 256; i++) memImg[i] = 16'($urandom);
        memImg[8'h00] = 16'h1234;
        memImg[8'h10] = 16'hBEEF;
        memImg[8'h11] = 16'hDEAD;

        #1 rst_ni = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkVal("rst_mem_req", 32'(memReq), 32'd0);
        checkVal("rst_instr", 32'(instr), 32'd0);
        checkVal("rst_instr_pc", 32'(instrPc), 32'd0);
        checkVal("rst_valid", 32'(instrValid), 32'd0);
        checkVal("rst_pc_enable", 32'(pcEnable), 32'd0);
        checkVal("rst_pc_select", 32'(pcSelect), 32'd0);
        checkVal("rst_fetch_err", 32'(fetchErr), 32'd0);

        $display("[TB] reset release and first fetch");
        rst_ni = 1'b1;
        checkVal("idle_mem_req", 32'(memReq), 32'd0);
        stepCycle(1'b1, 1'b1, 1'b0, 16'h0);
        checkVal("first_req", 32'(memReq), 32'd1);
        checkVal("first_addr", 32'(memAddr), 32'h0000);
        stepCycle(1'b1, 1'b1, 1'b0, 16'h0);
        checkVal("first_instr", 32'(instr), 32'h1234);
        checkVal("first_instr_pc", 32'(instrPc), 32'h0000);
        checkVal("first_valid", 32'(instrValid), 32'd1);
        checkVal("adv_pc_enable", 32'(pcEnable), 32'd1);
        checkVal("adv_pc_select", 32'(pcSelect), 32'd0);
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);

        $display("[TB] redirect to 0x0010 and wait-state fetch");
        stepCycle(1'b0, 1'b1, 1'b1, 16'h0010);
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        pcEnStart = pcEnCount;
        for (int i = 0; i < 3; i++) begin
            checkVal("wait_req", 32'(memReq), 32'd1);
            checkVal("wait_addr", 32'(memAddr), 32'h0010);
            stepCycle(1'b0, 1'b0, 1'b0, 16'h0);
        end
        checkVal("wait_req_last", 32'(memReq), 32'd1);
        stepCycle(1'b1, 1'b0, 1'b0, 16'h0);
        checkVal("beef_instr", 32'(instr), 32'hBEEF);

        $display("[TB] decode stall in HOLD");
        for (int i = 0; i < 5; i++) begin
            stepCycle(1'b1, 1'b0, 1'b0, 16'h0);
            checkVal("hold_valid", 32'(instrValid), 32'd1);
            checkVal("hold_instr", 32'(instr), 32'hBEEF);
            checkVal("hold_mem_req", 32'(memReq), 32'd0);
            checkVal("hold_pc_enable", 32'(pcEnable), 32'd0);
        end
        checkVal("one_pc_pulse", 32'(pcEnCount - pcEnStart), 32'd1);
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        checkVal("resume_valid", 32'(instrValid), 32'd0);
        checkVal("resume_req", 32'(memReq), 32'd1);
        checkVal("resume_addr", 32'(memAddr), 32'h0011);

        $display("[TB] flush beats coincident mem_ready");
        stepCycle(1'b1, 1'b0, 1'b1, 16'h0040);
        checkVal("flush_instr_kept", 32'(instr), 32'hBEEF);
        checkVal("flush_valid", 32'(instrValid), 32'd0);
        checkVal("redir_pc_enable", 32'(pcEnable), 32'd1);
        checkVal("redir_pc_select", 32'(pcSelect), 32'd1);
        stepCycle(1'b0, 1'b0, 1'b0, 16'h0);
        checkVal("redir_req", 32'(memReq), 32'd1);
        checkVal("redir_addr", 32'(memAddr), 32'h0040);

        $display("[TB] asynchronous reset mid-fetch");
        stepCycle(1'b1, 1'b0, 1'b0, 16'h0);
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        #3 rst_ni = 1'b0;
        #1;
        checkVal("async_mem_req", 32'(memReq), 32'd0);
        checkVal("async_valid", 32'(instrValid), 32'd0);
        checkVal("async_instr", 32'(instr), 32'd0);
        @(posedge clk);
        #1;
        resetModel();
        rst_ni = 1'b1;
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);

`ifdef FETCH_TIMEOUT_EN
        $display("[TB] fetch timeout");
        for (int i = 0; i < 14; i++) stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        checkVal("pre_timeout_err", 32'(fetchErr), 32'd0);
        checkVal("pre_timeout_req", 32'(memReq), 32'd1);
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        expErr = 1'b1;
        checkVal("timeout_err", 32'(fetchErr), 32'd1);
        checkVal("timeout_req", 32'(memReq), 32'd0);
        stepCycle(1'b0, 1'b1, 1'b1, 16'h0077);
        checkVal("halt_pc_enable", 32'(pcEnable), 32'd0);
        checkVal("halt_req", 32'(memReq), 32'd0);
        checkVal("halt_err", 32'(fetchErr), 32'd1);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        checkVal("err_cleared", 32'(fetchErr), 32'd0);
        resetModel();
        rst_ni = 1'b1;
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 14; i++) stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
        stepCycle(1'b1, 1'b0, 1'b0, 16'h0);
        checkVal("limit_edge_err", 32'(fetchErr), 32'd0);
        checkVal("limit_edge_valid", 32'(instrValid), 32'd1);
        stepCycle(1'b0, 1'b1, 1'b0, 16'h0);
`endif

        $display("[TB] random traffic");
        randStart = completions;
        for (int i = 0; i < 400; i++) begin
            rdy  = ($urandom_range(0, 9) < 6) || (waitRun >= 10);
            irdy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 99) < 8);
            stepCycle(rdy, irdy, fl, 16'($urandom_range(0, 255)));
        end
        checkVal("progress", 32'((completions - randStart) > 30), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
